// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: load-use interlock, branch flush, memory-wait freeze and
// a halt sequence that drains the front end with bubbles before stopping.
module pipe_ctrl #(
  parameter int unsigned AW           = 3,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned SC_W         = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   id_rs1,
  input  logic [AW-1:0]   id_rs2,
  input  logic            id_uses_rs1,
  input  logic            id_uses_rs2,
  input  logic [AW-1:0]   ex_rd,
  input  logic            ex_mem_read,
  input  logic            ex_branch_taken,
  input  logic            mem_req,
  input  logic            mem_ready,
  input  logic            halt_req,
  input  logic            resume,
  output logic            pc_en,
  output logic            if_id_en,
  output logic            id_ex_en,
  output logic            ex_mem_en,
  output logic            mem_wb_en,
  output logic            if_id_flush,
  output logic            id_ex_flush,
  output logic [1:0]      state,
  output logic            halted,
  output logic [SC_W-1:0] stall_count
);

  localparam int unsigned DcW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StMemWait  = 2'd1,
    StDrain    = 2'd2,
    StHalted   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [DcW-1:0]  drain_q, drain_d;
  logic [SC_W-1:0] stall_q;

  logic ms, lu;
  logic freeze, flush_both, lu_hold, bubble, drain_step, stall_inc;

  assign ms = mem_req & ~mem_ready;
  // Register 0 never carries a real dependency.
  assign lu = ex_mem_read & (ex_rd != '0) &
              ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    freeze     = 1'b0;
    flush_both = 1'b0;
    lu_hold    = 1'b0;
    bubble     = 1'b0;
    drain_step = 1'b0;
    stall_inc  = 1'b0;

    unique case (state_q)
      StRun: begin
        if (ms) begin
          freeze  = 1'b1;
          state_d = StMemWait;
        end else if (ex_branch_taken) begin
          flush_both = 1'b1;
        end else if (lu) begin
          lu_hold = 1'b1;
        end else if (halt_req) begin
          state_d = StDrain;
          drain_d = DcW'(DRAIN_CYCLES - 1);
        end
      end
      StMemWait: begin
        if (!mem_ready) begin
          freeze = 1'b1;
        end else begin
          state_d = StRun;
          if (ex_branch_taken) flush_both = 1'b1;
          else if (lu)         lu_hold    = 1'b1;
        end
      end
      StDrain: begin
        if (ms) begin
          freeze = 1'b1;
        end else if (ex_branch_taken) begin
          flush_both = 1'b1;
          drain_step = 1'b1;
        end else if (lu) begin
          lu_hold = 1'b1;
        end else begin
          bubble     = 1'b1;
          drain_step = 1'b1;
        end
      end
      StHalted: begin
        freeze = 1'b1;
        if (resume) state_d = StRun;
      end
    endcase

    if (drain_step) begin
      if (drain_q == '0) state_d = StHalted;
      else               drain_d = drain_q - DcW'(1);
    end

    // The halted freeze is not a stall; only hazard/memory freezes are counted.
    stall_inc = (freeze & (state_q != StHalted)) | lu_hold;
  end

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (reset || freeze) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (flush_both) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (lu_hold) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (bubble) begin
      pc_en       = 1'b0;
      if_id_flush = 1'b1;
    end
    if (reset) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StRun;
      drain_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + SC_W'(1);
    end
  end

  assign state       = state_q;
  assign halted      = (state_q == StHalted);
  assign stall_count = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: single-cycle vector table in RUN plus hand-written sequences
// for memory wait, drain/halt, asynchronous reset and stall-counter saturation.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic       mem_req, mem_ready, halt_req, resume;

  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush;
  logic [1:0]  state;
  logic        halted;
  logic [15:0] stall_count;

  logic        pc_en4, if_id_en4, id_ex_en4, ex_mem_en4, mem_wb_en4, if_id_flush4, id_ex_flush4;
  logic [1:0]  state4;
  logic        halted4;
  logic [3:0]  stall_count4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .halt_req(halt_req), .resume(resume), .pc_en(pc_en),
    .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .state(state), .halted(halted),
    .stall_count(stall_count)
  );

  pipe_ctrl #(.SC_W(4)) dut4 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .halt_req(halt_req), .resume(resume), .pc_en(pc_en4),
    .if_id_en(if_id_en4), .id_ex_en(id_ex_en4), .ex_mem_en(ex_mem_en4), .mem_wb_en(mem_wb_en4),
    .if_id_flush(if_id_flush4), .id_ex_flush(id_ex_flush4), .state(state4), .halted(halted4),
    .stall_count(stall_count4)
  );

  wire [4:0] en = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
  wire [1:0] fl = {if_id_flush, id_ex_flush};

  typedef struct {
    string      name;
    logic [2:0] rs1, rs2, rd;
    logic       u1, u2, mr, br, halt;
    logic [4:0] exp_en;
    logic [1:0] exp_fl;
    int         exp_inc;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_mem_read = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
    halt_req = 0; resume = 0;
  endtask

  // Called just after a negedge with inputs set: check outputs, clock, check state.
  task automatic step(input string name, input logic [4:0] e, input logic [1:0] f,
                      input int exp_state_after);
    #1;
    chk({name, ".en"}, int'(en), int'(e));
    chk({name, ".fl"}, int'(fl), int'(f));
    @(posedge clk); #1;
    chk({name, ".state"}, int'(state), exp_state_after);
    @(negedge clk);
  endtask

  vec_t vecs[10];
  int   sc0;

  initial begin
    vecs[0] = '{"idle",      0, 0, 0, 0, 0, 0, 0, 0, 5'b11111, 2'b00, 0};
    vecs[1] = '{"lu_rs2",    0, 3, 3, 0, 1, 1, 0, 0, 5'b00111, 2'b01, 1};
    vecs[2] = '{"lu_rd0",    0, 0, 0, 0, 1, 1, 0, 0, 5'b11111, 2'b00, 0};
    vecs[3] = '{"lu_rs1",    5, 1, 5, 1, 0, 1, 0, 0, 5'b00111, 2'b01, 1};
    vecs[4] = '{"rs1_unused",5, 1, 5, 0, 1, 1, 0, 0, 5'b11111, 2'b00, 0};
    vecs[5] = '{"not_load",  5, 5, 5, 1, 1, 0, 0, 0, 5'b11111, 2'b00, 0};
    vecs[6] = '{"branch",    0, 0, 0, 0, 0, 0, 1, 0, 5'b11111, 2'b11, 0};
    vecs[7] = '{"br_halt_lu",2, 0, 2, 1, 0, 1, 1, 1, 5'b11111, 2'b11, 0};
    vecs[8] = '{"lu_halt",   2, 7, 7, 0, 1, 1, 0, 1, 5'b00111, 2'b01, 1};
    vecs[9] = '{"lu_mismatch",2,4, 6, 1, 1, 1, 0, 0, 5'b11111, 2'b00, 0};

    idle_inputs();
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst.state", int'(state), 0);
    chk("rst.stall", int'(stall_count), 0);
    chk("rst.en", int'(en), 0);
    chk("rst.fl", int'(fl), 3);
    chk("rst.halted", int'(halted), 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2; ex_rd = vecs[i].rd;
      id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2; ex_mem_read = vecs[i].mr;
      ex_branch_taken = vecs[i].br; halt_req = vecs[i].halt;
      sc0 = int'(stall_count);
      step(vecs[i].name, vecs[i].exp_en, vecs[i].exp_fl, 0);
      chk({vecs[i].name, ".stall"}, int'(stall_count), sc0 + vecs[i].exp_inc);
    end
    idle_inputs();

    // Memory wait: three not-ready cycles then release.
    sc0 = int'(stall_count);
    mem_req = 1; mem_ready = 0;
    step("mw0", 5'b00000, 2'b00, 1);
    step("mw1", 5'b00000, 2'b00, 1);
    step("mw2", 5'b00000, 2'b00, 1);
    mem_ready = 1;
    step("mw_rel", 5'b11111, 2'b00, 0);
    chk("mw.stall", int'(stall_count), sc0 + 3);
    idle_inputs();

    // Halt pulse, three drain cycles, halted, resume.
    halt_req = 1;
    step("halt", 5'b11111, 2'b00, 2);
    halt_req = 0;
    step("dr0", 5'b01111, 2'b10, 2);
    step("dr1", 5'b01111, 2'b10, 2);
    step("dr2", 5'b01111, 2'b10, 3);
    chk("halted", int'(halted), 1);
    halt_req = 1;
    step("hlt_ign", 5'b00000, 2'b00, 3);
    halt_req = 0; resume = 1;
    step("resume", 5'b00000, 2'b00, 0);
    resume = 0;

    // Memory stall inside drain holds the drain counter.
    sc0 = int'(stall_count);
    halt_req = 1;
    step("halt2", 5'b11111, 2'b00, 2);
    halt_req = 0;
    step("d2_0", 5'b01111, 2'b10, 2);
    mem_req = 1; mem_ready = 0;
    step("d2_ms", 5'b00000, 2'b00, 2);
    mem_req = 0;
    step("d2_1", 5'b01111, 2'b10, 2);
    step("d2_2", 5'b01111, 2'b10, 3);
    chk("d2.stall", int'(stall_count), sc0 + 1);
    resume = 1;
    step("resume2", 5'b00000, 2'b00, 0);
    resume = 0;

    // Asynchronous reset in the middle of a drain.
    halt_req = 1;
    step("halt3", 5'b11111, 2'b00, 2);
    halt_req = 0;
    #2 reset = 1'b1;
    #1;
    chk("arst.state", int'(state), 0);
    chk("arst.stall", int'(stall_count), 0);
    chk("arst.en", int'(en), 0);
    chk("arst.fl", int'(fl), 3);
    @(posedge clk); #1;
    chk("arst.fl_hold", int'(fl), 3);
    @(negedge clk);
    reset = 1'b0;
    step("post_rst", 5'b11111, 2'b00, 0);

    // Saturation: 20 load-use cycles.
    reset = 1'b1;
    #1 reset = 1'b0;
    ex_mem_read = 1; ex_rd = 3; id_rs1 = 3; id_uses_rs1 = 1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
    end
    #1;
    chk("sat4", int'(stall_count4), 15);
    chk("sat16", int'(stall_count), 20);
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
